// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with glitch-rejecting start detection, sticky error flags and an FWFT byte FIFO; define UART_RX_PARITY_EN for 8E1 framing with a parity_err flag.
module uart_rx_fifo #(
    parameter int DIV_W   = 16,
    parameter int FIFO_AW = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DIV_W-1:0]   cfg_divider,
    input  logic               rx,
    input  logic               rd_en,
    output logic [7:0]         rd_data,
    output logic               rd_valid,
    output logic [FIFO_AW:0]   rx_count,
    output logic               frame_err,
    output logic               overrun,
    input  logic               err_clr
`ifdef UART_RX_PARITY_EN
    ,
    output logic               parity_err
`endif
);
    localparam int DEPTH = 2 ** FIFO_AW;
`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;
    logic perr_set;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
`endif
    state_t state, state_nxt;
    logic rx_meta, rxs;
    logic [DIV_W-1:0] cnt, cnt_nxt, div_q, div_nxt, div_eff;
    logic [2:0] idx, idx_nxt;
    logic [7:0] shreg, sh_nxt;
    logic tick, push, ferr_set, ovr_set, do_push, do_pop, full;
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [7:0] mem [DEPTH];

    assign div_eff = (cfg_divider < DIV_W'(4)) ? DIV_W'(4) : cfg_divider;
    assign tick    = (cnt == '0);

    // Two-flop synchronizer; resets high so reset never looks like a start bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // Receive FSM registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            div_q <= DIV_W'(4);
            idx   <= '0;
            shreg <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            div_q <= div_nxt;
            idx   <= idx_nxt;
            shreg <= sh_nxt;
        end
    end

    // Bit timing, mid-bit sampling and frame accept/reject decisions
    always_comb begin
        state_nxt = state;
        cnt_nxt   = tick ? cnt : cnt - 1'b1;
        div_nxt   = div_q;
        idx_nxt   = idx;
        sh_nxt    = shreg;
        push      = 1'b0;
        ferr_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_set  = 1'b0;
`endif
        case (state)
            IDLE: if (!rxs) begin
                state_nxt = START;
                div_nxt   = div_eff;
                cnt_nxt   = (div_eff >> 1) - 1'b1;
            end
            START: if (tick) begin
                state_nxt = rxs ? IDLE : DATA;
                cnt_nxt   = div_q - 1'b1;
                idx_nxt   = '0;
            end
            DATA: if (tick) begin
                sh_nxt  = {rxs, shreg[7:1]};
                idx_nxt = idx + 1'b1;
                cnt_nxt = div_q - 1'b1;
`ifdef UART_RX_PARITY_EN
                if (idx == 3'd7) state_nxt = PARITY;
`else
                if (idx == 3'd7) state_nxt = STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (tick) begin
                perr_set  = ^{shreg, rxs};
                state_nxt = STOP;
                cnt_nxt   = div_q - 1'b1;
            end
`endif
            STOP: if (tick) begin
                push      = rxs;
                ferr_set  = !rxs;
                state_nxt = rxs ? IDLE : BRK;
            end
            BRK: if (rxs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign full     = rx_count == (FIFO_AW+1)'(DEPTH);
    assign rd_valid = rx_count != '0;
    assign do_pop   = rd_en && rd_valid;
    assign do_push  = push && (!full || do_pop);
    assign ovr_set  = push && full && !do_pop;
    assign rd_data  = rd_valid ? mem[rd_ptr] : 8'h00;

    // Byte storage; unreset because rd_data is masked while empty
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= shreg;
    end

    // Pointers, occupancy and sticky error flags (a new error beats err_clr)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rx_count  <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            rx_count  <= rx_count + (FIFO_AW+1)'(do_push) - (FIFO_AW+1)'(do_pop);
            frame_err <= ferr_set | (frame_err & ~err_clr);
            overrun   <= ovr_set | (overrun & ~err_clr);
`ifdef UART_RX_PARITY_EN
            parity_err <= perr_set | (parity_err & ~err_clr);
`endif
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard bench for uart_rx_fifo with a queue-based FIFO model and serial frame driver.
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;
    logic        clk = 1'b0, reset = 1'b1, rx = 1'b1, rd_en = 1'b0, err_clr = 1'b0;
    logic [15:0] cfg_divider = 16'd50;
    logic [7:0]  rd_data;
    logic        rd_valid, frame_err, overrun;
    logic [4:0]  rx_count;
`ifdef UART_RX_PARITY_EN
    logic        parity_err;
`endif
    int          checks = 0, failures = 0;
    logic [7:0]  exp_q[$];
    logic        exp_ferr = 1'b0, exp_ovr = 1'b0;
    logic        drain = 1'b0, force_pop = 1'b0;
    logic [7:0]  last_pop = 8'h00;
    logic [15:0] c;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DIV_W(16), .FIFO_AW(4)) dut (
        .clk(clk), .reset(reset), .cfg_divider(cfg_divider), .rx(rx), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .rx_count(rx_count),
        .frame_err(frame_err), .overrun(overrun), .err_clr(err_clr)
`ifdef UART_RX_PARITY_EN
        , .parity_err(parity_err)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int eff(input logic [15:0] d);
        return (d < 16'd4) ? 4 : int'(d);
    endfunction

    // Consumer: random pops while draining, otherwise only directed pops
    initial forever begin
        @(posedge clk);
        #2;
        rd_en = drain ? ($urandom_range(0, 2) != 0) : force_pop;
    end

    // Monitor: every pop the DUT will take is compared against the model head
    initial forever begin
        @(negedge clk);
        if (!reset && rd_en && rd_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pop_unexpected: got 0x%0h, expected no data", rd_data);
            end else begin
                last_pop = rd_data;
                check("rd_data", rd_data, exp_q.pop_front());
            end
        end
    end

    // Drive one frame; stop_low>0 holds the stop bit low that many clocks; abort_bit>=0 stops mid that data bit
    task automatic send_frame(input logic [7:0] b, input int stop_low, input int abort_bit, input logic [15:0] next_cfg);
        int d, h, post, nb;
        logic [8:0] bits;
        d = eff(cfg_divider);
        h = d / 2;
        post = (d - h - 3 < 0) ? 0 : d - h - 3;
        bits = {^b, b};
`ifdef UART_RX_PARITY_EN
        nb = 9;
`else
        nb = 8;
`endif
        @(posedge clk);
        #1;
        rx = 1'b0;
        repeat (d) @(posedge clk);
        #1;
        for (int i = 0; i < nb; i++) begin
            rx = bits[i];
            if (i == 0) cfg_divider = next_cfg;
            if (i == abort_bit) begin
                repeat (h) @(posedge clk);
                #1;
                return;
            end
            repeat (d) @(posedge clk);
            #1;
        end
        rx = (stop_low == 0);
        repeat (h + 2) @(posedge clk);
        #1;
        check("count_pre_stop", rx_count, exp_q.size());
        check("valid_pre_stop", rd_valid, exp_q.size() != 0);
        @(posedge clk);
        #1;
        if (stop_low == 0) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(b);
            else exp_ovr = 1'b1;
            check("valid_post_stop", rd_valid, 1);
            check("count_post_stop", rx_count, exp_q.size());
            check("overrun", overrun, exp_ovr);
            check("frame_err", frame_err, exp_ferr);
`ifdef UART_RX_PARITY_EN
            check("parity_err", parity_err, 0);
`endif
            repeat (post) @(posedge clk);
            #1;
        end else begin
            exp_ferr = 1'b1;
            check("frame_err_set", frame_err, exp_ferr);
            check("count_after_ferr", rx_count, exp_q.size());
            err_clr = 1'b1;
            @(posedge clk);
            #1;
            err_clr = 1'b0;
            exp_ferr = 1'b0;
            check("frame_err_clr", frame_err, exp_ferr);
            repeat (stop_low - h - 4) @(posedge clk);
            #1;
            check("frame_err_once", frame_err, exp_ferr);
            rx = 1'b1;
            repeat (d) @(posedge clk);
            #1;
            check("frame_err_idle", frame_err, exp_ferr);
            check("count_after_break", rx_count, exp_q.size());
        end
    endtask

    task automatic glitch(input int k);
        int d;
        d = eff(cfg_divider);
        @(posedge clk);
        #1;
        rx = 1'b0;
        repeat (k) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (d + 4) @(posedge clk);
        #1;
        check("glitch_count", rx_count, exp_q.size());
        check("glitch_ferr", frame_err, exp_ferr);
    endtask

    task automatic drain_all();
        drain = 1'b1;
        for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (4) @(posedge clk);
        drain = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("drain_model_empty", exp_q.size(), 0);
        check("drain_count", rx_count, 0);
        check("drain_valid", rd_valid, 0);
    endtask

    task automatic clear_errors();
        @(posedge clk);
        #1;
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        exp_ferr = 1'b0;
        exp_ovr = 1'b0;
        check("overrun_clr", overrun, exp_ovr);
        check("frame_err_clr2", frame_err, exp_ferr);
    endtask

    task automatic check_reset_state();
        check("rst_valid", rd_valid, 0);
        check("rst_data", rd_data, 0);
        check("rst_count", rx_count, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovr", overrun, 0);
`ifdef UART_RX_PARITY_EN
        check("rst_perr", parity_err, 0);
`endif
    endtask

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, d, h;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state();
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        cfg_divider = 16'd50;
        send_frame(8'h55, 0, -1, cfg_divider);
        drain_all();
        glitch(10);
        send_frame(8'hA3, 60, -1, cfg_divider);
        check("ferr_fifo_empty", rx_count, 0);
        cfg_divider = 16'd16;
        for (int i = 0; i < 17; i++) send_frame(8'(i), 0, -1, cfg_divider);
        check("full_count", rx_count, 16);
        check("full_overrun", overrun, 1);
        drain_all();
        check("overrun_last_pop", last_pop, 8'h0F);
        clear_errors();
        for (int i = 0; i < 16; i++) send_frame(8'($urandom), 0, -1, cfg_divider);
        d = eff(cfg_divider);
        h = d / 2;
`ifdef UART_RX_PARITY_EN
        n = 2 + h + 10 * d;
`else
        n = 2 + h + 9 * d;
`endif
        fork
            send_frame(8'h7E, 0, -1, cfg_divider);
            begin
                @(posedge clk);
                #1;
                repeat (n) @(posedge clk);
                #1;
                force_pop = 1'b1;
                @(posedge clk);
                #1;
                force_pop = 1'b0;
            end
        join
        check("poppush_count", rx_count, 16);
        check("poppush_overrun", overrun, 0);
        drain_all();
        check("poppush_last", last_pop, 8'h7E);
        send_frame(8'h33, 0, -1, cfg_divider);
        send_frame(8'hF0, 0, 4, cfg_divider);
        reset = 1'b1;
        rx = 1'b1;
        exp_q.delete();
        exp_ferr = 1'b0;
        exp_ovr = 1'b0;
        #1;
        check_reset_state();
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3 * d) @(posedge clk);
        #1;
        check("no_partial_push", rx_count, 0);
        send_frame(8'h12, 0, -1, cfg_divider);
        drain_all();
        cfg_divider = 16'd2;
        send_frame(8'h5A, 0, -1, cfg_divider);
        send_frame(8'hC3, 0, -1, cfg_divider);
        drain_all();
        cfg_divider = 16'd20;
        send_frame(8'h96, 0, -1, 16'd33);
        send_frame(8'h69, 0, -1, cfg_divider);
        drain_all();
        for (int k = 0; k < 30; k++) begin
            c = ($urandom_range(0, 5) == 0) ? 16'($urandom_range(1, 3)) : 16'($urandom_range(4, 40));
            cfg_divider = c;
            drain = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 4) == 0) glitch($urandom_range(1, eff(c) / 2 - 1));
            send_frame(8'($urandom), 0, -1, cfg_divider);
        end
        drain_all();
        check("final_ovr", overrun, exp_ovr);
        check("final_ferr", frame_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
